uart_rx_freq: RTL and testbench
===============================

// Module: uart_rx_freq
// PURPOSE
//   UART receiver (8N1, LSB first) that loads the wave-frequency byte from the host link.
//   Sits upstream of the clock divider and drives its freqz input.
//   Runs on the 50 MHz system clock, advanced by a 1-cycle enable at 16x the baud rate (16*9600 Hz).
//   Holds the last accepted byte; 0x00 is never presented, which protects the divider from divide-by-zero.
// PARAMETERS
//   OVERSAMPLE  16    ticks per bit; mid-bit point = OVERSAMPLE/2
//   DATA_BITS   8     payload bits per frame
//   FREQ_RESET  8'd1  freq_out value after reset
// PORTS
//   clk        in   1          50 MHz system clock
//   rst        in   1          asynchronous reset, active-high
//   tick_16x   in   1          enable pulse, 1 clk wide, at OVERSAMPLE*baud
//   rxd        in   1          serial line, idle high, asynchronous to clk
//   freq_out   out  DATA_BITS  last accepted nonzero byte (feeds freqz)
//   rx_valid   out  1          1-clk pulse when freq_out updates
//   frame_err  out  1          1-clk pulse on a bad stop bit (or bad parity, see CONFIGURATION)
// BEHAVIOUR
//   Reset values
//   - freq_out=FREQ_RESET; rx_valid=0; frame_err=0; FSM=IDLE; counters=0.
//   - Synchronizer flops reset to 1 (idle line).
//   Synchronization
//   - rxd passes through a 2-flop synchronizer on clk. All sampling uses the synchronized bit.
//   - State and counters advance only on clk edges where tick_16x=1.
//   FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; any frame error -> WAIT_IDLE
//   - IDLE: on a tick with rx=0, clear tick_cnt and go to START.
//   - START: at tick_cnt=OVERSAMPLE/2-1 (mid-bit), resample:
//     - rx=1: false start, back to IDLE, no pulse.
//     - rx=0: clear tick_cnt and bit_cnt, go to DATA.
//   - DATA: sample every OVERSAMPLE ticks (tick_cnt=OVERSAMPLE-1) and shift into shreg, LSB first.
//     After DATA_BITS samples, go to STOP (or PARITY when enabled).
//   - STOP: sample at mid stop bit.
//     - rx=1, shreg!=0: freq_out<=shreg, rx_valid=1 for one clk; go to IDLE.
//     - rx=1, shreg==0: byte dropped, freq_out unchanged, no pulse; go to IDLE.
//     - rx=0: frame_err=1 for one clk, freq_out unchanged; go to WAIT_IDLE.
//   - WAIT_IDLE: stay until a tick sees rx=1, then IDLE (a break does not retrigger frames).
//   Timing
//   - rx_valid/frame_err assert on the clk edge that registers the mid-stop-bit tick.
//   - Latency from frame start edge: about 9.5 bit times + 2 clk synchronizer delay.
//   Boundaries
//   - Back-to-back frames: a start bit immediately after the stop mid-point is detected.
//     IDLE is re-entered half a bit early, so there is no dead time.
//   - rst mid-frame aborts the frame; all outputs return to reset values asynchronously.
//   - tick_16x held high continuously is legal; it advances one step per clk.
//   - tick_cnt is 4 bits and wraps at OVERSAMPLE-1 only; bit_cnt covers 0..DATA_BITS.
// CONFIGURATION
//   UART_RX_PARITY_EN defined
//   - A PARITY state follows DATA and samples one even-parity bit at its bit centre.
//   - Mismatch: frame_err pulse at that sample, go to WAIT_IDLE, freq_out unchanged.
//   - Frame is 8E1.
//   UART_RX_PARITY_EN undefined
//   - No PARITY state; frame is 8N1.
// TESTING
//   1. Send 0x5A at 9600 baud (16x ticks) -> freq_out=0x5A; exactly one rx_valid pulse; frame_err=0.
//   2. rxd low for 4 ticks, then high -> no state change past START; freq_out=0x01; no pulses.
//   3. Send 0x33 with stop bit=0 -> one frame_err pulse; freq_out keeps its prior value.
//      Line held low 3 bit times -> no new frame until rxd returns high.
//   4. Send 0x00 -> no rx_valid, no frame_err; freq_out unchanged.
//   5. Send 0x01 then 0xFF back-to-back with zero idle -> two rx_valid pulses; final freq_out=0xFF.
//   6. Assert rst during DATA bit 4 of 0xA5 -> freq_out=0x01 immediately.
//      The next clean frame 0x10 is received correctly.
//      With UART_RX_PARITY_EN: 0x07 with wrong parity -> frame_err, no update.

Source files
------------

// File: rtl/uart_rx_freq.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_freq
// Brief    : UART receiver, 8N1 LSB first (8E1 when UART_RX_PARITY_EN is
//            defined), holding the last nonzero byte for the freqz divider.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_freq #(
  parameter int                   OVERSAMPLE = 16,
  parameter int                   DATA_BITS  = 8,
  parameter logic [DATA_BITS-1:0] FREQ_RESET = 8'd1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_16x,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] freq_out,
  output logic                 rx_valid,
  output logic                 frame_err
);

  localparam int TCW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BCW = $clog2(DATA_BITS + 1);

  localparam logic [TCW-1:0] MID_TICK  = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] LAST_TICK = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY     = 3'd3;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic                 sync1_q, sync2_q;
  logic                 rx;
  logic [2:0]           state_q, state_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] freq_q, freq_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;

  assign rx = sync2_q;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    freq_d      = freq_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (tick_16x) begin
      case (state_q)
        S_IDLE: begin
          if (!rx) begin
            tick_cnt_d = '0;
            state_d    = S_START;
          end
        end
        S_START: begin
          if (tick_cnt_q == MID_TICK) begin
            if (rx) begin
              state_d = S_IDLE;
            end else begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              state_d    = S_DATA;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            shreg_d    = {rx, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = S_AFTER_DATA;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            if (rx != ^shreg_q) begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_IDLE;
            end else begin
              state_d = S_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Leaving at mid stop bit lets a back-to-back start edge be caught with no dead time.
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            if (!rx) begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_IDLE;
            end else begin
              if (shreg_q != '0) begin
                freq_d     = shreg_q;
                rx_valid_d = 1'b1;
              end
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (rx) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      freq_q      <= FREQ_RESET;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      freq_q      <= freq_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign freq_out  = freq_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_freq.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_freq
// Brief    : Directed, table-driven bench for uart_rx_freq (honours UART_RX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_freq;

  localparam int TICK_DIV = 3;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       tick_16x = 1'b0;
  logic       rxd      = 1'b1;
  logic [7:0] freq_out;
  logic       rx_valid;
  logic       frame_err;

  int n_vec  = 0;
  int n_err  = 0;
  int v_total = 0;
  int e_total = 0;
  int v0, e0;

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic       par_flip;
    logic [7:0] exp_freq;
    int         exp_v;
    int         exp_e;
  } vec_t;

  vec_t vecs [8];

  uart_rx_freq dut (
    .clk      (clk),
    .rst      (rst),
    .tick_16x (tick_16x),
    .rxd      (rxd),
    .freq_out (freq_out),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // One tick every TICK_DIV clocks so the enable gating is exercised.
  initial begin
    int tcnt;
    tcnt = 0;
    forever begin
      @(negedge clk);
      tick_16x = (tcnt == 0);
      tcnt = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
    end
  end

  // Counts high cycles, so a pulse wider than one clk shows up as an extra count.
  always @(negedge clk) begin
    if (rx_valid)  v_total <= v_total + 1;
    if (frame_err) e_total <= e_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) rxd = 1'b1;
`endif
    drive_bit(stop_b);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) drive_bit(1'b1);
  endtask

  task automatic snap();
    v0 = v_total;
    e0 = e_total;
  endtask

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1, 0};
    vecs[1] = '{8'h33, 1'b0, 1'b0, 8'h5A, 0, 1};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h5A, 0, 0};
    vecs[3] = '{8'h80, 1'b1, 1'b0, 8'h80, 1, 0};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 8'h01, 1, 0};
    vecs[5] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1, 0};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 8'hC3, 0, 1};
`ifdef UART_RX_PARITY_EN
    vecs[7] = '{8'h07, 1'b1, 1'b1, 8'hC3, 0, 1};
`else
    vecs[7] = '{8'h07, 1'b1, 1'b1, 8'h07, 1, 0};
`endif

    // Reset values
    repeat (4) @(negedge clk);
    check("reset_freq", {24'd0, freq_out}, 32'h01);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    idle_bits(2);

    // False start: 4 ticks low, then high
    snap();
    rxd = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    idle_bits(3);
    check("false_start_freq", {24'd0, freq_out}, 32'h01);
    check("false_start_valid", v_total - v0, 0);
    check("false_start_err", e_total - e0, 0);

    for (int i = 0; i < 8; i++) begin
      snap();
      send_frame(vecs[i].data, vecs[i].stop_b, vecs[i].par_flip);
      idle_bits(2);
      check($sformatf("vec%0d_freq", i), {24'd0, freq_out}, {24'd0, vecs[i].exp_freq});
      check($sformatf("vec%0d_valid", i), v_total - v0, vecs[i].exp_v);
      check($sformatf("vec%0d_err", i), e_total - e0, vecs[i].exp_e);
    end

    // Bad stop bit followed by a long break: only one error until the line returns high
    snap();
    send_frame(8'h33, 1'b0, 1'b0);
    repeat (12) drive_bit(1'b0);
    check("break_err", e_total - e0, 1);
    check("break_valid", v_total - v0, 0);
    idle_bits(2);
    snap();
    send_frame(8'h22, 1'b1, 1'b0);
    idle_bits(2);
    check("after_break_freq", {24'd0, freq_out}, 32'h22);
    check("after_break_valid", v_total - v0, 1);

    // Back-to-back frames, zero idle between them
    snap();
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(2);
    check("b2b_freq", {24'd0, freq_out}, 32'hFF);
    check("b2b_valid", v_total - v0, 2);
    check("b2b_err", e_total - e0, 0);

    // Reset in the middle of data bit 4 of 0xA5
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    rxd = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_freq", {24'd0, freq_out}, 32'h01);
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_err", {31'd0, frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    idle_bits(2);
    snap();
    send_frame(8'h10, 1'b1, 1'b0);
    idle_bits(2);
    check("post_rst_freq", {24'd0, freq_out}, 32'h10);
    check("post_rst_valid", v_total - v0, 1);
    check("post_rst_err", e_total - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
